fetch_stage: RTL and testbench

Instruction fetch stage with integrated IF/ID pipeline register. It owns the program counter and issues one-at-a-time requests to instruction memory over a ready/valid handshake. It delivers each fetched instruction word with its PC to the decode stage, where the immediate generator and control decoder consume `id_inst`. It honours a decode-stage stall, and a branch/jump redirect flushes in-flight work.

---
 rtl/fetch_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with an integrated IF/ID pipeline register. Owns
//   the program counter and keeps at most one instruction-memory request in
//   flight. Fetched words are handed to decode together with their PC.
//   Decode can stall the stage, and a redirect flushes all in-flight work.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   imem_req_o / imem_addr_o      request valid and word-aligned address (= pc)
//   imem_ready_i                  memory accepts the request this cycle
//   imem_rvalid_i / imem_rdata_i  response valid and instruction word
//   stall_i                       decode cannot accept; hold IF/ID
//   redirect_i / redirect_pc_i    control-flow change and its target
//   id_valid_o, id_inst_o         IF/ID contents presented to decode
//   id_pc_o, id_pc_plus4_o        PC of id_inst_o and that PC + 4
//
// fetch_stage_chk is a simulation-only protocol monitor on the memory port.
// ----------------------------------------------------------------------------

module fetch_stage_chk (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic ready_i,
   input  logic rvalid_i
);
   logic outstanding_q;
   logic orphan_ok_q;

   // Track whether the memory owes a response. A request abandoned by reset
   // may still answer once, so one response is tolerated after reset until
   // the next acceptance.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_q <= 1'b0;
         orphan_ok_q   <= 1'b1;
      end else begin
         if (req_i && ready_i) begin
            outstanding_q <= 1'b1;
         end else if (rvalid_i) begin
            outstanding_q <= 1'b0;
         end else begin
            outstanding_q <= outstanding_q;
         end
         if ((req_i && ready_i) || rvalid_i) begin
            orphan_ok_q <= 1'b0;
         end else begin
            orphan_ok_q <= orphan_ok_q;
         end
      end
   end

   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      rvalid_i |-> (outstanding_q || orphan_ok_q));

   a_single_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i && ready_i) |-> (!outstanding_q || rvalid_i));
endmodule

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc_plus4_o
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;

   logic can_take_s;
   logic resp_s;
   logic req_s;
   logic accept_s;

   // Handshake terms: a new request may overlap the response that frees the
   // single outstanding slot, but only if decode can take that response.
   always_comb begin
      can_take_s = !(id_valid_q && stall_i);
      resp_s     = (state_q == S_WAIT) && imem_rvalid_i;
      req_s      = !rst_i && !redirect_i && !skid_valid_q &&
                   ((state_q == S_IDLE) || (resp_s && can_take_s));
      accept_s   = req_s && imem_ready_i;
   end

   // Next-state logic for PC, FSM, skid buffer and IF/ID register.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      id_valid_d   = id_valid_q;
      id_inst_d    = id_inst_q;
      id_pc_d      = id_pc_q;

      if (redirect_i) begin
         pc_d         = {redirect_pc_i[31:2], 2'b00};
         skid_valid_d = 1'b0;
         id_valid_d   = 1'b0;
         id_inst_d    = NOP_INST;
         // A response arriving with the redirect is simply discarded. In DROP
         // the arriving response is the one being dropped, so leaving DROP
         // here avoids waiting for a response that will never come.
         case (state_q)
            S_WAIT:  state_d = imem_rvalid_i ? S_IDLE : S_DROP;
            S_DROP:  state_d = imem_rvalid_i ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase
      end else begin
         if (accept_s) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end else begin
            req_pc_d = req_pc_q;
         end

         case (state_q)
            S_IDLE:  state_d = accept_s ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = (imem_rvalid_i && !accept_s) ? S_IDLE : S_WAIT;
            S_DROP:  state_d = imem_rvalid_i ? S_IDLE : S_DROP;
            default: state_d = S_IDLE;
         endcase

         if (can_take_s) begin
            // Skid entry is older than any response, so it goes first.
            if (skid_valid_q) begin
               id_valid_d   = 1'b1;
               id_inst_d    = skid_inst_q;
               id_pc_d      = skid_pc_q;
               skid_valid_d = 1'b0;
            end else if (resp_s) begin
               id_valid_d = 1'b1;
               id_inst_d  = imem_rdata_i;
               id_pc_d    = req_pc_q;
            end else begin
               id_valid_d = 1'b0;
               id_inst_d  = NOP_INST;
            end
         end else begin
            if (resp_s) begin
               skid_valid_d = 1'b1;
               skid_inst_d  = imem_rdata_i;
               skid_pc_d    = req_pc_q;
            end else begin
               skid_valid_d = skid_valid_q;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'h0000_0000;
         skid_valid_q <= 1'b0;
         skid_inst_q  <= NOP_INST;
         skid_pc_q    <= 32'h0000_0000;
         id_valid_q   <= 1'b0;
         id_inst_q    <= NOP_INST;
         id_pc_q      <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         id_valid_q   <= id_valid_d;
         id_inst_q    <= id_inst_d;
         id_pc_q      <= id_pc_d;
      end
   end

   // Output drive.
   always_comb begin
      imem_req_o    = req_s;
      imem_addr_o   = pc_q;
      id_valid_o    = id_valid_q;
      id_inst_o     = id_inst_q;
      id_pc_o       = id_pc_q;
      id_pc_plus4_o = id_pc_q + 32'd4;
   end

   fetch_stage_chk u_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_s),
      .ready_i  (imem_ready_i),
      .rvalid_i (imem_rvalid_i)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Bench for fetch_stage. A behavioural memory answers accepted requests
//   after a chosen latency with addr ^ 32'hA5A5_0000. The reference model
//   tracks program order only: the next address to be fetched and the next
//   PC decode must receive, both advancing by 4 and jumping on redirect.
//   Directed scenarios come first, then a randomized run.
// ----------------------------------------------------------------------------

module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, imem_req, imem_ready, imem_rvalid, stall, redirect, id_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc, id_pc_plus4;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (imem_ready),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_valid_o    (id_valid),
      .id_inst_o     (id_inst),
      .id_pc_o       (id_pc),
      .id_pc_plus4_o (id_pc_plus4)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // stimulus knobs
   logic        g_rst, g_stall, g_redirect;
   logic [31:0] g_rpc;
   int          lat_fix;
   bit          lat_rand, rdy_rand, rdy_val;

   // memory: outstanding addresses with remaining cycles until response
   logic [31:0] q_addr[$];
   int          q_cnt[$];

   // reference model
   logic [31:0] exp_pc, exp_fetch, hold_pc, hold_inst;
   bit          chk_flush, chk_hold;
   int          delivered = 0;

   // per-cycle samples
   logic        s_req, s_acc, s_idv;
   logic [31:0] s_addr, s_pc, s_inst;

   task automatic cycle();
      int l;
      @(negedge clk);
      rst         = g_rst;
      stall       = g_stall;
      redirect    = g_redirect;
      redirect_pc = g_rpc;
      imem_ready  = rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_val;
      if (q_addr.size() > 0 && q_cnt[0] == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_cnt.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      s_req  = imem_req;
      s_addr = imem_addr;
      s_acc  = imem_req && imem_ready;
      s_idv  = id_valid;
      s_pc   = id_pc;
      s_inst = id_inst;
      if (g_rst) begin
         check("req_in_reset", 32'(imem_req), 32'd0);
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
         chk_flush = 1'b0;
         chk_hold  = 1'b0;
      end else begin
         if (chk_flush) begin
            check("flush_valid", 32'(id_valid), 32'd0);
            check("flush_inst", id_inst, NOP);
         end
         if (chk_hold) begin
            check("hold_valid", 32'(id_valid), 32'd1);
            check("hold_pc", id_pc, hold_pc);
            check("hold_inst", id_inst, hold_inst);
         end
         chk_flush = redirect;
         chk_hold  = id_valid && stall && !redirect;
         hold_pc   = id_pc;
         hold_inst = id_inst;
         if (id_valid && !stall) begin
            check("id_pc", id_pc, exp_pc);
            check("id_inst", id_inst, mem_word(exp_pc));
            check("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (s_acc) begin
            check("one_outstanding", 32'(q_addr.size()), 32'd0);
            check("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            l = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
            q_addr.push_back(imem_addr);
            q_cnt.push_back(l);
         end
         if (redirect) begin
            check("req_on_redirect", 32'(imem_req), 32'd0);
            exp_pc    = {g_rpc[31:2], 2'b00};
            exp_fetch = {g_rpc[31:2], 2'b00};
         end
      end
      foreach (q_cnt[i]) if (q_cnt[i] > 0) q_cnt[i] = q_cnt[i] - 1;
   endtask

   task automatic wait_acc(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s_acc) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idv(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (s_idv) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Let any outstanding response return, then reset for two cycles.
   task automatic do_reset();
      rdy_rand   = 1'b0;
      rdy_val    = 1'b0;
      g_stall    = 1'b0;
      g_redirect = 1'b0;
      for (int i = 0; i < 10 && q_addr.size() > 0; i++) cycle();
      check("drained", 32'(q_addr.size()), 32'd0);
      g_rst = 1'b1;
      cycle();
      cycle();
      check("rst_id_valid", 32'(s_idv), 32'd0);
      check("rst_id_inst", s_inst, NOP);
      check("rst_id_pc", s_pc, 32'd0);
      g_rst   = 1'b0;
      rdy_val = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      g_rst = 1'b1; g_stall = 1'b0; g_redirect = 1'b0; g_rpc = 32'd0;
      lat_fix = 1; lat_rand = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1;

      // Sequential fetch, 1-cycle memory
      do_reset();
      cycle();
      check("first_req", 32'(s_req), 32'd1);
      check("first_addr", s_addr, RESET_PC);
      cycle();
      check("idv_before_first", 32'(s_idv), 32'd0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("seq_valid", 32'(s_idv), 32'd1);
         check("seq_pc", s_pc, 32'(4 * i));
      end

      // Stall with skid: three stall cycles while id_pc = 8
      g_stall = 1'b1;
      cycle();
      check("stall_pc0", s_pc, 32'd8);
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("skid_req_off", 32'(s_req), 32'd0);
         check("stall_pc", s_pc, 32'd8);
      end
      g_stall = 1'b0;
      cycle();
      check("drain_req_off", 32'(s_req), 32'd0);
      check("drain_pc", s_pc, 32'd8);
      cycle();
      check("after_skid_pc", s_pc, 32'd12);
      check("after_skid_addr", s_addr, 32'd16);
      cycle();
      cycle();
      check("after_skid_pc16", s_pc, 32'd16);

      // Redirect one cycle after acceptance of PC 8, 3-cycle memory
      lat_fix = 3;
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (s_acc && s_addr == 32'd8) begin
            ok = 1'b1;
            break;
         end
      end
      check("acc8_seen", 32'(ok), 32'd1);
      g_redirect = 1'b1; g_rpc = 32'h100;
      cycle();
      g_redirect = 1'b0;
      wait_idv(ok);
      check("redir_idv_seen", 32'(ok), 32'd1);
      check("redir_first_pc", s_pc, 32'h100);

      // Redirect in the same cycle as a response
      lat_fix = 1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (q_addr.size() > 0 && q_cnt[0] == 0) begin
            ok = 1'b1;
            break;
         end
         cycle();
      end
      check("rvalid_pending", 32'(ok), 32'd1);
      g_redirect = 1'b1; g_rpc = 32'h200;
      cycle();
      g_redirect = 1'b0;
      cycle();
      check("simul_req", 32'(s_req), 32'd1);
      check("simul_addr", s_addr, 32'h200);

      // Redirect during stall with an unaligned target
      g_stall = 1'b1;
      wait_idv(ok);
      check("stall_idv_seen", 32'(ok), 32'd1);
      g_redirect = 1'b1; g_rpc = 32'h403;
      cycle();
      g_redirect = 1'b0;
      cycle();
      check("stall_redir_valid", 32'(s_idv), 32'd0);
      check("stall_redir_inst", s_inst, 32'h13);
      for (int i = 0; i < 20 && !s_req; i++) cycle();
      check("stall_redir_req", 32'(s_req), 32'd1);
      check("stall_redir_addr", s_addr, 32'h400);
      g_stall = 1'b0;

      // PC wrap
      g_redirect = 1'b1; g_rpc = 32'hFFFF_FFFC;
      cycle();
      g_redirect = 1'b0;
      wait_acc(ok);
      check("wrap_acc1", 32'(ok), 32'd1);
      check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
      wait_acc(ok);
      check("wrap_acc2", 32'(ok), 32'd1);
      check("wrap_addr2", s_addr, 32'd0);

      // Reset while a request is outstanding; late response must be ignored
      lat_fix = 3;
      wait_acc(ok);
      check("mid_acc", 32'(ok), 32'd1);
      cycle();
      g_rst = 1'b1; rdy_val = 1'b0;
      cycle();
      g_rst = 1'b0;
      cycle();
      check("late_idv", 32'(s_idv), 32'd0);
      check("late_req", 32'(s_req), 32'd1);
      check("late_addr", s_addr, RESET_PC);
      cycle();
      check("late_ignored", 32'(s_idv), 32'd0);
      rdy_val = 1'b1;
      wait_acc(ok);
      check("post_rst_acc", 32'(ok), 32'd1);
      check("post_rst_addr", s_addr, RESET_PC);
      wait_idv(ok);
      check("post_rst_idv", 32'(ok), 32'd1);
      check("post_rst_pc", s_pc, RESET_PC);
      check("post_rst_inst", s_inst, mem_word(RESET_PC));

      // Randomized run
      rdy_rand = 1'b1;
      lat_rand = 1'b1;
      delivered = 0;
      for (int i = 0; i < 3000; i++) begin
         g_stall    = ($urandom_range(0, 3) == 0);
         g_redirect = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 3))
            0:       g_rpc = $urandom;
            1:       g_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: g_rpc = 32'($urandom_range(0, 1023));
         endcase
         cycle();
      end
      check("liveness", 32'(delivered > 200), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
